// File: rtl/lora_reg_pkg.sv
// Shared definitions for the SX1278 register sequencer: SPI word layout,
// in-flight frame kinds, sequencer states and the power-up init table.
package lora_reg_pkg;

    localparam int WORD_W   = 16;
    localparam int WNR_BIT  = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        INFL_NONE = 2'd0,
        INFL_INIT = 2'd1,
        INFL_CMD  = 2'd2
    } inflight_e;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // LoRa sleep, 434 MHz Frf, PA config, modem config, then standby.
    function automatic logic [WORD_W-1:0] init_word(input logic [4:0] idx);
        case (idx)
            5'd0:    init_word = 16'h8180;
            5'd1:    init_word = 16'h866C;
            5'd2:    init_word = 16'h8780;
            5'd3:    init_word = 16'h8800;
            5'd4:    init_word = 16'h898F;
            5'd5:    init_word = 16'h9D72;
            5'd6:    init_word = 16'h9E74;
            5'd7:    init_word = 16'h8181;
            default: init_word = 16'h4200;
        endcase
    endfunction

endpackage

// File: rtl/lora_frame_sync.sv
// Frame-boundary detector for the free-running SPI controller plus a
// watchdog that flags a controller that has stopped completing frames.
module lora_frame_sync #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_busy,
    output logic fb,
    output logic spi_stall
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

    logic            busy_q;
    logic [WD_W-1:0] wd;

    // A frame ends on the falling edge of busy.
    assign fb        = busy_q & ~spi_busy;
    assign spi_stall = (wd >= WD_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            wd     <= '0;
        end else begin
            busy_q <= spi_busy;
            if (fb)
                wd <= '0;
            else if (wd < WD_MAX)
                wd <= wd + WD_W'(1);
        end
    end

endmodule

// File: rtl/lora_reg_sequencer.sv
// Supplies spi_controller with one 16-bit word per frame: the SX1278 init
// table after reset, then single register accesses from a valid/ready port.
module lora_reg_sequencer
    import lora_reg_pkg::*;
#(
    parameter int          INIT_LEN    = 8,
    parameter logic [15:0] IDLE_WORD   = 16'h4200,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic        spi_busy,
    output logic [15:0] spi_word,
    output logic        cmd_done,
    output logic        init_done,
    output logic        spi_stall
);

    localparam logic [4:0] IDX_LEN = 5'(INIT_LEN);

    state_e              state_q, state_d;
    inflight_e           inflight_q;
    logic [4:0]          idx;
    logic                slot_full;
    logic [WORD_W-1:0]   slot_word;
    logic                fb;
    logic                accept;
    logic                load_init;
    logic                load_slot;
    logic                last_init_done;

    lora_frame_sync #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_sync (
        .clk       (clk),
        .reset     (reset),
        .spi_busy  (spi_busy),
        .fb        (fb),
        .spi_stall (spi_stall)
    );

    assign accept    = cmd_valid & cmd_ready;
    assign load_init = (state_q == S_INIT) && (idx < IDX_LEN);
    assign load_slot = !load_init && slot_full;
    // idx has already moved past the last entry by the time that entry completes.
    assign last_init_done = fb && (inflight_q == INFL_INIT) && (idx == IDX_LEN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_INIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (last_init_done) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_RUN) && !slot_full;
        init_done = (state_q == S_RUN);
    end

    // The word only ever changes on a frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spi_word   <= IDLE_WORD;
            idx        <= '0;
            inflight_q <= INFL_NONE;
            slot_full  <= 1'b0;
            cmd_done   <= 1'b0;
        end else begin
            cmd_done <= fb && (inflight_q == INFL_CMD);
            if (fb) begin
                if (load_init) begin
                    spi_word   <= init_word(idx);
                    idx        <= idx + 5'd1;
                    inflight_q <= INFL_INIT;
                end else if (load_slot) begin
                    spi_word   <= slot_word;
                    inflight_q <= INFL_CMD;
                end else begin
                    spi_word   <= IDLE_WORD;
                    inflight_q <= INFL_NONE;
                end
            end
            if (accept)
                slot_full <= 1'b1;
            else if (fb && load_slot)
                slot_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_word[WNR_BIT]           <= cmd_write;
            slot_word[ADDR_MSB:ADDR_LSB] <= cmd_addr;
            slot_word[DATA_MSB:DATA_LSB] <= cmd_wdata;
        end
    end

endmodule

// File: tb/tb_lora_reg_sequencer.sv
// Bench for lora_reg_sequencer: a behavioural SPI frame source, a frame-level
// reference model and a scoreboard monitor checking every clock.
module tb_lora_reg_sequencer;

    localparam logic [15:0] IDLE = 16'h4200;
    localparam int          TMO  = 255;
    localparam logic [15:0] INIT_TBL [8] = '{16'h8180, 16'h866C, 16'h8780, 16'h8800,
                                             16'h898F, 16'h9D72, 16'h9E74, 16'h8181};

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        spi_busy;
    logic [15:0] spi_word;
    logic        cmd_done;
    logic        init_done;
    logic        spi_stall;

    always #10 clk = ~clk;

    lora_reg_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .spi_busy  (spi_busy),
        .spi_word  (spi_word),
        .cmd_done  (cmd_done),
        .init_done (init_done),
        .spi_stall (spi_stall)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: frame-level queues
    logic [15:0] init_q [$];
    logic [15:0] pend_q [$];
    logic [15:0] exp_word_q [$];
    int          exp_done_q [$];
    int          m_infl;        // 0 idle, 1 init entry, 2 user command
    bit          m_init_done;
    int          m_since_fb;
    int          init_loaded;
    bit          b_prev;

    // SPI controller stand-in
    int          phase;
    bit          hold;
    bit          fb_next;
    logic [15:0] mosi_acc;
    logic [15:0] mosi_last;
    bit          mosi_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        init_q.delete();
        for (int i = 0; i < 8; i++) init_q.push_back(INIT_TBL[i]);
        pend_q.delete();
        exp_word_q.delete();
        exp_done_q.delete();
        m_infl      = 0;
        m_init_done = 0;
        m_since_fb  = 0;
        init_loaded = 0;
        b_prev      = 0;
    endtask

    // Model: advances one step per clock edge.
    initial begin
        bit          fb_e;
        bit          acc_e;
        logic [15:0] w;
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                model_reset();
            end else begin
                fb_e   = b_prev & ~spi_busy;
                b_prev = spi_busy;
                acc_e  = cmd_valid & cmd_ready;
                if (fb_e) begin
                    if (m_infl == 2) exp_done_q.push_back(cyc);
                    if (m_infl == 1 && init_q.size() == 0) m_init_done = 1;
                    if (init_q.size() != 0) begin
                        w = init_q.pop_front();
                        m_infl = 1;
                        init_loaded++;
                    end else if (pend_q.size() != 0) begin
                        w = pend_q.pop_front();
                        m_infl = 2;
                    end else begin
                        w = IDLE;
                        m_infl = 0;
                    end
                    exp_word_q.push_back(w);
                    m_since_fb = 0;
                end else if (m_since_fb < 100000) begin
                    m_since_fb++;
                end
                if (acc_e) pend_q.push_back({cmd_write, cmd_addr, cmd_wdata});
            end
        end
    end

    // SPI frame source: 2 idle clocks + 32 busy clocks, MOSI sampled MSB first.
    initial begin
        phase = 0; hold = 0; fb_next = 0; mosi_valid = 0;
        mosi_acc = '0; mosi_last = '0; spi_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                phase = 0; spi_busy = 1'b0; mosi_valid = 0; fb_next = 0;
            end else begin
                fb_next  = (phase == 0) && spi_busy;
                spi_busy = (phase >= 2);
                if (phase >= 2 && (phase % 2) == 0) mosi_acc[15 - (phase - 2) / 2] = spi_word[15 - (phase - 2) / 2];
                if (phase == 33) begin
                    mosi_last  = mosi_acc;
                    mosi_valid = 1;
                end
                if (!(hold && phase >= 2)) phase = (phase == 33) ? 0 : phase + 1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [15:0] prev_word;
        logic [15:0] last_exp;
        logic [15:0] w;
        bit          popped;
        bit          exp_d;
        prev_word = IDLE;
        last_exp  = IDLE;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                check("rst_spi_word", spi_word, IDLE);
                check("rst_cmd_ready", cmd_ready, 0);
                check("rst_cmd_done", cmd_done, 0);
                check("rst_init_done", init_done, 0);
                check("rst_spi_stall", spi_stall, 0);
                prev_word = IDLE;
                last_exp  = IDLE;
            end else begin
                popped = 0;
                if (exp_word_q.size() != 0) begin
                    w = exp_word_q.pop_front();
                    popped = 1;
                    check("frame_word", spi_word, w);
                    if (mosi_valid) check("mosi_bits", mosi_last, last_exp);
                    last_exp = w;
                end
                if (!popped) check("word_stable_mid_frame", spi_word, prev_word);
                prev_word = spi_word;
                exp_d = (exp_done_q.size() != 0) && (exp_done_q[0] == cyc);
                check("cmd_done", cmd_done, exp_d);
                if (exp_d) void'(exp_done_q.pop_front());
                check("init_done", init_done, m_init_done);
                check("cmd_ready", cmd_ready, m_init_done && pend_q.size() == 0);
                check("spi_stall", spi_stall, m_since_fb >= TMO);
            end
        end
    end

    task automatic send_cmd(input bit w, input logic [6:0] a, input logic [7:0] d);
        int n;
        bit done;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0; done = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            done = cmd_ready;
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom);
        check("cmd_accept_in_time", done, 1);
    endtask

    task automatic wait_frames(input int n);
        repeat (n * 34) @(negedge clk);
    endtask

    initial begin
        int n;
        bit ok;
        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (5) @(negedge clk);
        reset = 1'b1;

        // Command issued during init waits for the table to finish.
        send_cmd(1'b1, 7'h01, 8'h83);
        wait_frames(3);

        // Back-to-back commands
        send_cmd(1'b1, 7'h0D, 8'h00);
        send_cmd(1'b1, 7'h0D, 8'h80);
        send_cmd(1'b0, 7'h0D, 8'h00);
        wait_frames(4);

        // Accept landing exactly on a frame boundary
        n = 0;
        do begin @(negedge clk); n++; end while (!(fb_next && cmd_ready) && n < 500);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h5A; cmd_wdata = 8'hA5;
        @(posedge clk);
        ok = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_on_fb", ok, 1);
        wait_frames(3);

        // Randomized traffic
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            send_cmd(1'($urandom), 7'($urandom), 8'($urandom));
        end
        wait_frames(3);

        // Stalled SPI controller
        hold = 1;
        repeat (300) @(negedge clk);
        hold = 0;
        wait_frames(2);

        // Reset while a command frame is in flight
        send_cmd(1'b1, 7'h22, 8'h33);
        n = 0;
        while (m_infl != 2 && n < 500) begin @(negedge clk); n++; end
        check("cmd_in_flight_reached", m_infl, 2);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset while init entry 4 is on the wire
        n = 0;
        while (init_loaded < 5 && n < 1000) begin @(negedge clk); n++; end
        check("init_entry4_reached", init_loaded, 5);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        send_cmd(1'b0, 7'h42, 8'h00);
        wait_frames(4);
        check("word_queue_drained", exp_word_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);
        check("final_init_done", init_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(60000 * 20);
        errors++;
        $display("FAIL global_timeout: simulation exceeded cycle budget at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
